// File: rtl/multicycle_control_unit_if.sv
// rtl/multicycle_control_unit_if.sv - request/ready handshakes between the control unit and imem, dmem and MDU
interface multicycle_control_unit_if;
   logic imem_req;
   logic imem_ready;
   logic dmem_read;
   logic dmem_write;
   logic dmem_ready;
   logic mdu_start;
   logic mdu_done;

   modport master (
      output imem_req, dmem_read, dmem_write, mdu_start,
      input  imem_ready, dmem_ready, mdu_done
   );

   modport slave (
      input  imem_req, dmem_read, dmem_write, mdu_start,
      output imem_ready, dmem_ready, mdu_done
   );
endinterface

// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - RV32I multi-cycle sequencer with handshake timeouts, sticky trap and counters
module multicycle_control_unit #(
   parameter int CORE      = 0,
   parameter int ENABLE_M  = 0,
   parameter int TIMEOUT   = 64,
   parameter int CNT_WIDTH = 32
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [6:0]            opcode,
   input  logic                  funct7_0,
   input  logic                  report,
   multicycle_control_unit_if.master hs,
   output logic [2:0]            state,
   output logic                  ir_write,
   output logic                  pc_write,
   output logic                  reg_write,
   output logic                  memtoReg,
   output logic [2:0]            ALUOp,
   output logic [1:0]            operand_A_sel,
   output logic                  operand_B_sel,
   output logic [1:0]            extend_sel,
   output logic [1:0]            next_PC_sel,
   output logic                  illegal,
   output logic                  timeout,
   output logic [CNT_WIDTH-1:0]  cycles,
   output logic [CNT_WIDTH-1:0]  instret
);
   typedef enum logic [2:0] {
      S_FETCH     = 3'd0,
      S_DECODE    = 3'd1,
      S_EXECUTE   = 3'd2,
      S_MEMORY    = 3'd3,
      S_WRITEBACK = 3'd4,
      S_TRAP      = 3'd5
   } state_t;

   localparam int WW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [WW-1:0] WAIT_LAST = WW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   state_t            state_q, state_d;
   logic [WW-1:0]     wait_q;
   logic              mdu_busy_q;
   logic              illegal_q, timeout_q;
   logic [CNT_WIDTH-1:0] cycles_q, instret_q;
   logic              set_illegal, set_timeout, expired, decode_window;
   logic              imem_req_c, dmem_read_c, dmem_write_c, mdu_start_c;

   logic is_r, is_i, is_load, is_store, is_branch, is_jal, is_jalr, is_auipc, is_lui, is_nop;
   logic is_legal, is_mdu;

   assign is_r      = (opcode == 7'b0110011);
   assign is_i      = (opcode == 7'b0010011);
   assign is_load   = (opcode == 7'b0000011);
   assign is_store  = (opcode == 7'b0100011);
   assign is_branch = (opcode == 7'b1100011);
   assign is_jal    = (opcode == 7'b1101111);
   assign is_jalr   = (opcode == 7'b1100111);
   assign is_auipc  = (opcode == 7'b0010111);
   assign is_lui    = (opcode == 7'b0110111);
   assign is_nop    = (opcode == 7'b0001111) || (opcode == 7'b1110011);
   assign is_legal  = is_r | is_i | is_load | is_store | is_branch | is_jal | is_jalr
                    | is_auipc | is_lui | is_nop;
   assign is_mdu    = (ENABLE_M != 0) && is_r && funct7_0;

   // The awaited ready has been missing for TIMEOUT-1 cycles; this is the last chance.
   assign expired       = (TIMEOUT > 0) && (wait_q == WAIT_LAST);
   assign decode_window = (state_q == S_DECODE) || (state_q == S_EXECUTE)
                        || (state_q == S_MEMORY) || (state_q == S_WRITEBACK);

   always_comb begin
      state_d       = state_q;
      set_illegal   = 1'b0;
      set_timeout   = 1'b0;
      imem_req_c    = 1'b0;
      dmem_read_c   = 1'b0;
      dmem_write_c  = 1'b0;
      mdu_start_c   = 1'b0;
      ir_write      = 1'b0;
      pc_write      = 1'b0;
      reg_write     = 1'b0;
      next_PC_sel   = 2'b00;
      ALUOp         = 3'b000;
      operand_A_sel = 2'b00;
      operand_B_sel = 1'b0;
      extend_sel    = 2'b00;
      memtoReg      = 1'b0;

      case (state_q)
         S_FETCH: begin
            imem_req_c = 1'b1;
            if (hs.imem_ready) begin
               ir_write = 1'b1;
               state_d  = S_DECODE;
            end else if (expired) begin
               state_d     = S_TRAP;
               set_timeout = 1'b1;
            end
         end
         S_DECODE: begin
            if (!is_legal) begin
               state_d     = S_TRAP;
               set_illegal = 1'b1;
            end else if (is_nop) begin
               pc_write = 1'b1;
               state_d  = S_FETCH;
            end else begin
               state_d = S_EXECUTE;
            end
         end
         S_EXECUTE: begin
            if (is_mdu) begin
               mdu_start_c = !mdu_busy_q;
               if (hs.mdu_done) begin
                  state_d = S_WRITEBACK;
               end else if (expired) begin
                  state_d     = S_TRAP;
                  set_timeout = 1'b1;
               end
            end else if (is_load || is_store) begin
               state_d = S_MEMORY;
            end else if (is_branch) begin
               pc_write    = 1'b1;
               next_PC_sel = 2'b01;
               state_d     = S_FETCH;
            end else begin
               state_d = S_WRITEBACK;
            end
         end
         S_MEMORY: begin
            dmem_read_c  = is_load;
            dmem_write_c = is_store;
            if (hs.dmem_ready) begin
               if (is_store) begin
                  pc_write = 1'b1;
                  state_d  = S_FETCH;
               end else begin
                  state_d = S_WRITEBACK;
               end
            end else if (expired) begin
               state_d     = S_TRAP;
               set_timeout = 1'b1;
            end
         end
         S_WRITEBACK: begin
            reg_write   = 1'b1;
            pc_write    = 1'b1;
            next_PC_sel = is_jal ? 2'b10 : (is_jalr ? 2'b11 : 2'b00);
            state_d     = S_FETCH;
         end
         S_TRAP: state_d = S_TRAP;
         default: state_d = S_FETCH;
      endcase

      if (decode_window) begin
         if (is_r)                   ALUOp = 3'b000;
         else if (is_i)              ALUOp = 3'b001;
         else if (is_branch)         ALUOp = 3'b010;
         else if (is_jal || is_jalr) ALUOp = 3'b011;
         else if (is_load)           ALUOp = 3'b100;
         else if (is_store)          ALUOp = 3'b101;
         else if (is_auipc || is_lui) ALUOp = 3'b110;
         if (is_auipc)               operand_A_sel = 2'b01;
         else if (is_jal || is_jalr) operand_A_sel = 2'b10;
         else if (is_lui)            operand_A_sel = 2'b11;
         operand_B_sel = is_i | is_store | is_load | is_auipc | is_lui;
         if (is_store)               extend_sel = 2'b01;
         else if (is_auipc || is_lui) extend_sel = 2'b10;
         memtoReg = is_load;
      end

      // Held in reset: keep fetching but suppress every pulse so nothing half-commits.
      if (!reset) begin
         imem_req_c   = 1'b1;
         dmem_read_c  = 1'b0;
         dmem_write_c = 1'b0;
         mdu_start_c  = 1'b0;
         ir_write     = 1'b0;
         pc_write     = 1'b0;
         reg_write    = 1'b0;
         next_PC_sel  = 2'b00;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= S_FETCH;
         wait_q     <= '0;
         mdu_busy_q <= 1'b0;
         illegal_q  <= 1'b0;
         timeout_q  <= 1'b0;
         cycles_q   <= '0;
         instret_q  <= '0;
      end else begin
         state_q    <= state_d;
         wait_q     <= ((state_d == state_q) && (state_q != S_TRAP)) ? wait_q + WW'(1) : '0;
         mdu_busy_q <= (state_q == S_EXECUTE) && (state_d == S_EXECUTE);
         illegal_q  <= illegal_q | set_illegal;
         timeout_q  <= timeout_q | set_timeout;
         cycles_q   <= cycles_q + CNT_WIDTH'(1);
         if (pc_write) instret_q <= instret_q + CNT_WIDTH'(1);
      end
   end

`ifndef SYNTHESIS
   always @(posedge clock) begin
      if (reset && report)
         $display("core %0d cycles %0d state %0d opcode %b imem_req %b ir_write %b pc_write %b dmem_read %b dmem_write %b reg_write %b memtoReg %b mdu_start %b ALUOp %b A %b B %b ext %b npc %b illegal %b timeout %b",
                  CORE, cycles_q, state_q, opcode, imem_req_c, ir_write, pc_write, dmem_read_c,
                  dmem_write_c, reg_write, memtoReg, mdu_start_c, ALUOp, operand_A_sel,
                  operand_B_sel, extend_sel, next_PC_sel, illegal_q, timeout_q);
   end
`endif

   assign hs.imem_req   = imem_req_c;
   assign hs.dmem_read  = dmem_read_c;
   assign hs.dmem_write = dmem_write_c;
   assign hs.mdu_start  = mdu_start_c;
   assign state         = state_q;
   assign illegal       = illegal_q;
   assign timeout       = timeout_q;
   assign cycles        = cycles_q;
   assign instret       = instret_q;
endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb/tb_multicycle_control_unit.sv - randomized self-checking bench for multicycle_control_unit
module tb_multicycle_control_unit;
   localparam int TO = 6;
   localparam int CW = 4;

   localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_L = 7'b0000011,
                          OP_S = 7'b0100011, OP_B = 7'b1100011, OP_JAL = 7'b1101111,
                          OP_JALR = 7'b1100111, OP_AUIPC = 7'b0010111, OP_LUI = 7'b0110111,
                          OP_FENCE = 7'b0001111, OP_SYS = 7'b1110011;

   typedef struct packed {
      logic [2:0] st;
      logic       ireq, ir, pcw, rw, dr, dw, ms;
      logic [1:0] npc;
      logic       imr, dmr, mdd;
   } cyc_t;

   logic clock = 1'b0;
   logic reset = 1'b0;
   logic [6:0] opcode;
   logic funct7_0, report;
   logic [2:0] state, ALUOp;
   logic ir_write, pc_write, reg_write, memtoReg, operand_B_sel, illegal, timeout;
   logic [1:0] operand_A_sel, extend_sel, next_PC_sel;
   logic [CW-1:0] cycles, instret;

   int checks = 0;
   int failures = 0;
   int m_cycles = 0;
   int m_instret = 0;

   multicycle_control_unit_if hs();

   multicycle_control_unit #(.CORE(0), .ENABLE_M(1), .TIMEOUT(TO), .CNT_WIDTH(CW)) dut (
      .clock(clock), .reset(reset), .opcode(opcode), .funct7_0(funct7_0), .report(report),
      .hs(hs.master), .state(state), .ir_write(ir_write), .pc_write(pc_write),
      .reg_write(reg_write), .memtoReg(memtoReg), .ALUOp(ALUOp), .operand_A_sel(operand_A_sel),
      .operand_B_sel(operand_B_sel), .extend_sel(extend_sel), .next_PC_sel(next_PC_sel),
      .illegal(illegal), .timeout(timeout), .cycles(cycles), .instret(instret)
   );

   always #5 clock = ~clock;

   wire [22:0] ctrl_v = {state, hs.imem_req, ir_write, pc_write, reg_write, hs.dmem_read,
                         hs.dmem_write, hs.mdu_start, next_PC_sel, ALUOp, operand_A_sel,
                         operand_B_sel, extend_sel, memtoReg, illegal, timeout};

   // Operand/ALU encodings an instruction class should present while it is in flight.
   function automatic logic [8:0] dec_exp(input logic [6:0] op, input logic [2:0] st);
      logic [2:0] alu;
      logic [1:0] a, ext;
      logic b, mtr;
      alu = 3'd0; a = 2'd0; b = 1'b0; ext = 2'd0; mtr = 1'b0;
      if (st >= 3'd1 && st <= 3'd4) begin
         case (op)
            OP_I:           begin alu = 3'd1; b = 1'b1; end
            OP_B:           alu = 3'd2;
            OP_JAL, OP_JALR: begin alu = 3'd3; a = 2'd2; end
            OP_L:           begin alu = 3'd4; b = 1'b1; mtr = 1'b1; end
            OP_S:           begin alu = 3'd5; b = 1'b1; ext = 2'd1; end
            OP_AUIPC:       begin alu = 3'd6; a = 2'd1; b = 1'b1; ext = 2'd2; end
            OP_LUI:         begin alu = 3'd6; a = 2'd3; b = 1'b1; ext = 2'd2; end
            default:        ;
         endcase
      end
      return {alu, a, b, ext, mtr};
   endfunction

   // Builds the cycle-by-cycle expectation of one instruction and plays it against the DUT.
   task automatic run_instr(input logic [6:0] op, input logic f7, input int il, input int dl, input int ml);
      cyc_t q[$];
      cyc_t c;
      logic [22:0] exp_v;
      bit mdu, mem, nop;
      mdu = (op == OP_R) && f7;
      mem = (op == OP_L) || (op == OP_S);
      nop = (op == OP_FENCE) || (op == OP_SYS);
      for (int i = 0; i <= il; i++) begin
         c = '0; c.st = 3'd0; c.ireq = 1'b1; c.imr = (i == il); c.ir = (i == il); q.push_back(c);
      end
      c = '0; c.st = 3'd1; c.pcw = nop; q.push_back(c);
      if (!nop) begin
         if (op == OP_B) begin
            c = '0; c.st = 3'd2; c.pcw = 1'b1; c.npc = 2'd1; q.push_back(c);
         end else if (mem) begin
            c = '0; c.st = 3'd2; q.push_back(c);
            for (int i = 0; i <= dl; i++) begin
               c = '0; c.st = 3'd3; c.dr = (op == OP_L); c.dw = (op == OP_S);
               c.dmr = (i == dl); c.pcw = (op == OP_S) && (i == dl); q.push_back(c);
            end
         end else if (mdu) begin
            for (int i = 0; i <= ml; i++) begin
               c = '0; c.st = 3'd2; c.ms = (i == 0); c.mdd = (i == ml); q.push_back(c);
            end
         end else begin
            c = '0; c.st = 3'd2; q.push_back(c);
         end
         if (op != OP_B && op != OP_S) begin
            c = '0; c.st = 3'd4; c.rw = 1'b1; c.pcw = 1'b1;
            c.npc = (op == OP_JAL) ? 2'd2 : ((op == OP_JALR) ? 2'd3 : 2'd0);
            q.push_back(c);
         end
      end
      opcode = op; funct7_0 = f7;
      foreach (q[k]) begin
         c = q[k];
         hs.imem_ready = c.imr; hs.dmem_ready = c.dmr; hs.mdu_done = c.mdd;
         #1;
         exp_v = {c.st, c.ireq, c.ir, c.pcw, c.rw, c.dr, c.dw, c.ms, c.npc, dec_exp(op, c.st), 2'b00};
         checks++;
         if (ctrl_v !== exp_v) begin
            failures++;
            $display("FAIL ctrl op=%b step=%0d got=%h exp=%h", op, k, ctrl_v, exp_v);
         end
         checks++;
         if (cycles !== CW'(m_cycles) || instret !== CW'(m_instret)) begin
            failures++;
            $display("FAIL counters op=%b step=%0d got=%0d/%0d exp=%0d/%0d", op, k, cycles, instret,
                     CW'(m_cycles), CW'(m_instret));
         end
         m_cycles++;
         if (c.pcw) m_instret++;
         @(negedge clock);
      end
      hs.imem_ready = 1'b0; hs.dmem_ready = 1'b0; hs.mdu_done = 1'b0;
   endtask

   task automatic apply_reset();
      reset = 1'b0;
      hs.imem_ready = 1'b0; hs.dmem_ready = 1'b0; hs.mdu_done = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      m_cycles = 0; m_instret = 0;
   endtask

   task automatic test_reset();
      reset = 1'b0; opcode = OP_I;
      hs.imem_ready = 1'b1; hs.dmem_ready = 1'b1; hs.mdu_done = 1'b1;
      for (int i = 0; i < 2; i++) begin
         #1;
         checks++;
         if (ctrl_v !== {3'd0, 1'b1, 19'd0} || cycles !== '0 || instret !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%h cyc=%0d ret=%0d exp=%h 0 0", ctrl_v, cycles, instret,
                     {3'd0, 1'b1, 19'd0});
         end
         @(negedge clock);
      end
      reset = 1'b1;
      hs.imem_ready = 1'b0; hs.dmem_ready = 1'b0; hs.mdu_done = 1'b0;
      m_cycles = 0; m_instret = 0;
   endtask

   task automatic test_addi();
      apply_reset();
      run_instr(OP_I, 1'b0, 0, 0, 0);
      checks++;
      if (cycles !== 4'd4 || instret !== 4'd1) begin
         failures++;
         $display("FAIL addi_counts got=%0d/%0d exp=4/1", cycles, instret);
      end
   endtask

   task automatic test_load_delayed();
      logic [CW-1:0] c0;
      c0 = cycles;
      run_instr(OP_L, 1'b0, 0, 3, 0);
      checks++;
      if (CW'(cycles - c0) !== 4'd8) begin
         failures++;
         $display("FAIL load_latency got=%0d exp=8", CW'(cycles - c0));
      end
   endtask

   task automatic test_mul();
      run_instr(OP_R, 1'b1, 0, 0, 5);
      run_instr(OP_R, 1'b1, 0, 0, 0);
      run_instr(OP_R, 1'b0, 0, 0, 0);
   endtask

   task automatic test_ready_last_cycle();
      apply_reset();
      run_instr(OP_I, 1'b0, TO - 1, 0, 0);
      run_instr(OP_S, 1'b0, 0, TO - 1, 0);
      run_instr(OP_R, 1'b1, 0, 0, TO - 1);
   endtask

   task automatic test_timeout_fetch();
      apply_reset();
      opcode = OP_I;
      for (int i = 0; i < TO; i++) begin
         #1;
         checks++;
         if (state !== 3'd0 || hs.imem_req !== 1'b1 || timeout !== 1'b0) begin
            failures++;
            $display("FAIL fetch_wait i=%0d got st=%0d req=%b to=%b exp st=0 req=1 to=0", i, state, hs.imem_req, timeout);
         end
         @(negedge clock);
      end
      for (int i = 0; i < 2; i++) begin
         #1;
         checks++;
         if (ctrl_v !== {3'd5, 19'd0, 1'b1}) begin
            failures++;
            $display("FAIL fetch_timeout_trap got=%h exp=%h", ctrl_v, {3'd5, 19'd0, 1'b1});
         end
         @(negedge clock);
      end
   endtask

   task automatic test_timeout_mem();
      apply_reset();
      opcode = OP_S; funct7_0 = 1'b0;
      hs.imem_ready = 1'b1;
      @(negedge clock);
      hs.imem_ready = 1'b0;
      repeat (2) @(negedge clock);
      for (int i = 0; i < TO; i++) begin
         #1;
         checks++;
         if (state !== 3'd3 || hs.dmem_write !== 1'b1 || pc_write !== 1'b0) begin
            failures++;
            $display("FAIL mem_wait i=%0d got st=%0d dw=%b pcw=%b exp st=3 dw=1 pcw=0", i, state, hs.dmem_write, pc_write);
         end
         @(negedge clock);
      end
      #1;
      checks++;
      if (ctrl_v !== {3'd5, 19'd0, 1'b1}) begin
         failures++;
         $display("FAIL mem_timeout_trap got=%h exp=%h", ctrl_v, {3'd5, 19'd0, 1'b1});
      end
      @(negedge clock);
   endtask

   task automatic test_illegal();
      apply_reset();
      opcode = 7'b1111111; funct7_0 = 1'b0;
      hs.imem_ready = 1'b1;
      #1;
      checks++;
      if (ctrl_v !== {3'd0, 2'b11, 18'd0}) begin
         failures++;
         $display("FAIL illegal_fetch got=%h exp=%h", ctrl_v, {3'd0, 2'b11, 18'd0});
      end
      @(negedge clock);
      hs.imem_ready = 1'b0;
      #1;
      checks++;
      if (ctrl_v !== {3'd1, 20'd0}) begin
         failures++;
         $display("FAIL illegal_decode got=%h exp=%h", ctrl_v, {3'd1, 20'd0});
      end
      @(negedge clock);
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++;
         if (ctrl_v !== {3'd5, 18'd0, 2'b10}) begin
            failures++;
            $display("FAIL illegal_trap i=%0d got=%h exp=%h", i, ctrl_v, {3'd5, 18'd0, 2'b10});
         end
         @(negedge clock);
      end
      #2 reset = 1'b0;
      #1;
      checks++;
      if (state !== 3'd0 || illegal !== 1'b0 || hs.imem_req !== 1'b1) begin
         failures++;
         $display("FAIL illegal_clear got st=%0d ill=%b req=%b exp st=0 ill=0 req=1", state, illegal, hs.imem_req);
      end
      @(negedge clock);
      reset = 1'b1;
      m_cycles = 0; m_instret = 0;
   endtask

   task automatic test_mid_reset();
      apply_reset();
      opcode = OP_L; funct7_0 = 1'b0;
      hs.imem_ready = 1'b1;
      @(negedge clock);
      hs.imem_ready = 1'b0;
      repeat (2) @(negedge clock);
      #1;
      checks++;
      if (state !== 3'd3 || hs.dmem_read !== 1'b1) begin
         failures++;
         $display("FAIL midreset_mem got st=%0d dr=%b exp st=3 dr=1", state, hs.dmem_read);
      end
      #1 reset = 1'b0;
      #1;
      checks++;
      if (ctrl_v !== {3'd0, 1'b1, 19'd0} || cycles !== '0 || instret !== '0) begin
         failures++;
         $display("FAIL midreset_abort got=%h cyc=%0d ret=%0d exp=%h 0 0", ctrl_v, cycles, instret, {3'd0, 1'b1, 19'd0});
      end
      hs.dmem_ready = 1'b1;
      @(posedge clock);
      #1;
      checks++;
      if (pc_write !== 1'b0 || reg_write !== 1'b0 || state !== 3'd0 || instret !== '0) begin
         failures++;
         $display("FAIL midreset_nocommit got pcw=%b rw=%b st=%0d ret=%0d exp 0 0 0 0", pc_write, reg_write, state, instret);
      end
      @(negedge clock);
      hs.dmem_ready = 1'b0;
      reset = 1'b1;
      m_cycles = 0; m_instret = 0;
   endtask

   task automatic test_random();
      logic [6:0] ops [11];
      logic [6:0] op;
      ops = '{OP_R, OP_I, OP_L, OP_S, OP_B, OP_JAL, OP_JALR, OP_AUIPC, OP_LUI, OP_FENCE, OP_SYS};
      apply_reset();
      for (int n = 0; n < 30; n++) begin
         op = ops[$urandom_range(0, 10)];
         run_instr(op, 1'($urandom_range(0, 1)), $urandom_range(0, TO - 1),
                   $urandom_range(0, TO - 1), $urandom_range(0, TO - 1));
      end
   endtask

   task automatic test_wrap();
      apply_reset();
      repeat (17) run_instr(OP_FENCE, 1'b0, 0, 0, 0);
      checks++;
      if (instret !== 4'd1 || cycles !== 4'd2) begin
         failures++;
         $display("FAIL counter_wrap got=%0d/%0d exp=1/2", instret, cycles);
      end
   endtask

   initial begin
      opcode = 7'd0; funct7_0 = 1'b0; report = 1'b0;
      hs.imem_ready = 1'b0; hs.dmem_ready = 1'b0; hs.mdu_done = 1'b0;
      @(negedge clock);
      test_reset();
      test_addi();
      test_load_delayed();
      test_mul();
      test_ready_last_cycle();
      test_timeout_fetch();
      test_timeout_mem();
      test_illegal();
      test_mid_reset();
      test_random();
      test_wrap();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

Parametrised multi-cycle successor to the single-cycle decode-only control unit. It sequences each RV32I instruction through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK states. Memory and optional M-extension units are driven through ready/done handshakes, with per-wait timeouts and a sticky trap state. It sits between the instruction register and the datapath of the multi-cycle core, and keeps the established ALUOp, extend_sel, operand and next-PC select encodings.

## Interface
- CORE, 0: core index, used in report output only
- ENABLE_M, 0: 1 = R_TYPE with funct7_0=1 is a multi-cycle MDU op; 0 = treated as plain R_TYPE
- TIMEOUT, 64: maximum wait cycles for any handshake; 0 disables timeouts
- CNT_WIDTH, 32: width of the cycle and retired-instruction counters
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low reset
- opcode  in  7  opcode field from the instruction register (stable from DECODE onward)
- funct7_0  in  1  instruction bit 25 (M-extension select)
- imem_ready  in  1  instruction memory has delivered the word
- dmem_ready  in  1  data memory has completed the access
- mdu_done  in  1  MDU result valid
- report  in  1  prints a state dump this cycle
- state  out  3  FETCH=0, DECODE=1, EXECUTE=2, MEMORY=3, WRITEBACK=4, TRAP=5
- imem_req, ir_write, pc_write, dmem_read, dmem_write, reg_write, memtoReg, mdu_start  out  1 each
- ALUOp  out  3; operand_A_sel  out  2; operand_B_sel  out  1; extend_sel  out  2; next_PC_sel  out  2
- illegal, timeout  out  1  sticky trap causes
- cycles, instret  out  CNT_WIDTH  free-running cycle count; retired-instruction count

## Operation
- Decode encodings (valid in DECODE..WRITEBACK, 0 otherwise):
  - ALUOp: R=000, I=001, BRANCH=010, JAL/JALR=011, LOAD=100, STORE=101, AUIPC/LUI=110
  - operand_A_sel: AUIPC=01, JAL/JALR=10, LUI=11, else 00
  - operand_B_sel: 1 for I/STORE/LOAD/AUIPC/LUI
  - extend_sel: STORE=01, AUIPC/LUI=10, else 00
  - memtoReg: 1 for LOAD
- FETCH: imem_req=1. On imem_ready, pulse ir_write and go to DECODE.
- DECODE:
  - Opcode not in {R, I, LOAD, STORE, BRANCH, JAL, JALR, AUIPC, LUI, FENCE, SYSCALL} -> TRAP, set illegal.
  - FENCE/SYSCALL -> NOP: pulse pc_write with next_PC_sel=00, go to FETCH.
  - Otherwise go to EXECUTE.
- EXECUTE:
  - MDU op: pulse mdu_start in the first EXECUTE cycle only, then hold until mdu_done and go to WRITEBACK.
  - LOAD/STORE -> MEMORY.
  - BRANCH: pulse pc_write with next_PC_sel=01 (datapath chooses taken/not-taken), go to FETCH.
  - All others -> WRITEBACK.
- MEMORY: hold dmem_read (LOAD) or dmem_write (STORE) until dmem_ready.
  - STORE: pulse pc_write (next_PC_sel=00), go to FETCH.
  - LOAD: go to WRITEBACK.
- WRITEBACK: reg_write=1 and pc_write=1 for one cycle, then go to FETCH.
  - next_PC_sel: JAL=10, JALR=11, else 00.
- TRAP: all enables and requests are 0. Exit only via reset.
- Timeout: wait counter (width clog2(TIMEOUT+1)) clears on entry to FETCH/MEMORY/MDU-wait and increments each cycle without the awaited ready/done.
  - After TIMEOUT consecutive cycles without it -> TRAP, set timeout.
  - A ready arriving in the TIMEOUT-th cycle wins; no trap.
- Counters:
  - cycles increments every cycle out of reset.
  - instret increments in every cycle with pc_write=1.
  - Both wrap modulo 2^CNT_WIDTH.

## Timing
- Control outputs are Moore/decode-combinational from registered state and the held opcode. State, flags, wait counter and counters are registered.
- Reset (asynchronous, active-low): state=FETCH, cycles=0, instret=0, illegal=0, timeout=0, wait counter=0.
  - While in reset: imem_req=1; every other output is 0.
- A ready asserted in the same cycle as its request is accepted.
- Minimum cycles per instruction (zero-wait memory):
  - FENCE/SYSCALL = 2; BRANCH = 3; R/I/AUIPC/LUI/JAL/JALR/STORE = 4; LOAD = 5.
  - MDU = 4 + cycles until mdu_done.
- Pulse outputs (ir_write, pc_write, mdu_start, reg_write) are high for exactly one cycle per instruction.
- Reset asserted mid-instruction aborts immediately. No partial pc_write or reg_write occurs after reset assertion.
- report: at the clock edge, $display CORE, cycles, state, opcode and all control outputs.

## Test plan
- Reset release, then ADDI with imem_ready/dmem_ready tied to 1:
  - state sequence 0,1,2,4,0; reg_write and pc_write in cycle 4; instret=1 after 4 cycles.
- LW with dmem_ready delayed 3 cycles:
  - dmem_read high for 4 cycles; memtoReg=1; ALUOp=100; total 8 cycles.
- ENABLE_M=1, MUL (opcode 0110011, funct7_0=1), mdu_done after 5 cycles:
  - mdu_start is a single pulse; WRITEBACK follows the done cycle.
- TIMEOUT=4, imem_ready held 0:
  - TRAP entered after 4 FETCH cycles, timeout=1, imem_req=0.
  - Repeat with ready in the 4th cycle: no trap.
- opcode 7'b1111111: TRAP from DECODE, illegal=1, pc_write never asserted.
  - Assert reset: illegal=0, state=FETCH.
- CNT_WIDTH=4 with 17 NOPs (FENCE): instret wraps to 1; cycles wraps correctly.
